// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the data port and the shared memory bus around mem_port_arbiter.
// slave is the arbiter's view of the bundle; master is the requesters' and memory model's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner_d;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output if_done, if_rdata, d_done, d_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, busy, owner_d
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_done, if_rdata, d_done, d_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, busy, owner_d
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and data load/store.
// Each access holds mem_en for LATENCY cycles. Define ARB_RR_EN to break ties round-robin.
module mem_port_arbiter #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  state_t            stateNext;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addrLat;
  logic [DATA_W-1:0] wdataLat;
  logic              wrLat;
  logic              ownerD;
  logic              cancel;
  logic [DATA_W-1:0] ifRdata;
  logic [DATA_W-1:0] dRdata;
  logic              grantAny;
  logic              grantD;
  logic              inAccess;

`ifdef ARB_RR_EN
  // Set when the data port won the most recent tie, so the next tie goes to fetch.
  logic rrLastD;
`endif

  always_comb begin
    grantAny = bus.if_req | bus.d_req;
`ifdef ARB_RR_EN
    grantD   = bus.d_req & (~bus.if_req | ~rrLastD);
`else
    grantD   = bus.d_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    bus.mem_en   = 1'b0;
    bus.busy     = 1'b0;
    bus.if_done  = 1'b0;
    bus.d_done   = 1'b0;
    case (state)
      IDLE: begin
        if (grantAny) stateNext = ACCESS;
      end
      ACCESS: begin
        bus.mem_en = 1'b1;
        bus.busy   = 1'b1;
        if (cnt == '0) stateNext = RESP;
      end
      RESP: begin
        bus.busy    = 1'b1;
        bus.if_done = ~ownerD & ~cancel;
        bus.d_done  = ownerD & ~cancel;
        stateNext   = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bus fields are forced to zero outside ACCESS so the latches need no reset.
  assign inAccess      = (state == ACCESS);
  assign bus.mem_wr    = inAccess & wrLat;
  assign bus.mem_addr  = inAccess ? addrLat  : '0;
  assign bus.mem_wdata = inAccess ? wdataLat : '0;
  assign bus.owner_d   = ownerD;
  assign bus.if_rdata  = ifRdata;
  assign bus.d_rdata   = dRdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      ownerD  <= 1'b0;
      cancel  <= 1'b0;
      ifRdata <= '0;
      dRdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantAny) begin
            ownerD <= grantD;
            cnt    <= CNT_W'(LATENCY - 1);
          end
        end
        ACCESS: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          if (!ownerD && !bus.if_req) cancel <= 1'b1;
          if (cnt == '0 && !wrLat) begin
            if (ownerD) dRdata  <= bus.mem_rdata;
            else        ifRdata <= bus.mem_rdata;
          end
        end
        RESP: cancel <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) rrLastD <= 1'b0;
    else if (state == IDLE && bus.if_req && bus.d_req) rrLastD <= grantD;
  end
`endif

  always_ff @(posedge clk) begin
    if (state == IDLE && grantAny) begin
      addrLat  <= grantD ? bus.d_addr : bus.if_addr;
      wrLat    <= grantD & bus.d_wr;
      wdataLat <= bus.d_wdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-timing reference model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(.LATENCY(LAT), .ADDR_W(16), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory seen by the DUT: writes land on the LAT-th consecutive mem_en cycle.
  logic [15:0] simMem [0:255];
  int enRun = 0;
  assign bus.mem_rdata = simMem[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (enRun + 1 == LAT && bus.mem_wr) simMem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      enRun <= enRun + 1;
    end else begin
      enRun <= 0;
    end
  end

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: a grant at cycle S gives mem_en over S+1..S+LAT, done at S+LAT+1.
  logic [15:0] refMem [0:255];
  int          cyc = 0;
  bit          act = 0;
  int          start = 0;
  bit          eOwn = 0;
  bit          eWr = 0;
  bit          eCan = 0;
  bit          postRst = 0;
  bit          rrLastD = 0;
  logic [15:0] eAddr = '0;
  logic [15:0] eWd = '0;
  logic [15:0] eIfR = '0;
  logic [15:0] eDR = '0;

  task automatic checkOutputs();
    int k;
    bit inAcc, inResp;
    k      = cyc - start;
    inAcc  = act && k >= 1 && k <= LAT;
    inResp = act && k == LAT + 1;
    checkEq("mem_en",   bus.mem_en,   inAcc);
    checkEq("busy",     bus.busy,     inAcc || inResp);
    checkEq("if_done",  bus.if_done,  inResp && !eOwn && !eCan);
    checkEq("d_done",   bus.d_done,   inResp && eOwn);
    checkEq("owner_d",  bus.owner_d,  eOwn);
    checkEq("if_rdata", bus.if_rdata, eIfR);
    checkEq("d_rdata",  bus.d_rdata,  eDR);
    if (inAcc) begin
      checkEq("mem_wr",   bus.mem_wr,   eWr);
      checkEq("mem_addr", bus.mem_addr, eAddr);
      if (eWr) checkEq("mem_wdata", bus.mem_wdata, eWd);
    end
    if (postRst) begin
      checkEq("rst_mem_wr",    bus.mem_wr,    0);
      checkEq("rst_mem_addr",  bus.mem_addr,  0);
      checkEq("rst_mem_wdata", bus.mem_wdata, 0);
      postRst = 0;
    end
  endtask

  task automatic modelStep();
    int  k;
    bit  gD;
    if (act) begin
      k = cyc - start;
      if (k >= 1 && k <= LAT) begin
        if (!eOwn && !bus.if_req) eCan = 1;
        if (k == LAT) begin
          if (eWr)       refMem[eAddr[7:0]] = eWd;
          else if (eOwn) eDR  = refMem[eAddr[7:0]];
          else           eIfR = refMem[eAddr[7:0]];
        end
      end else if (k == LAT + 1) begin
        act  = 0;
        eCan = 0;
      end
    end else if (!rst && (bus.if_req || bus.d_req)) begin
      if (bus.if_req && bus.d_req) begin
`ifdef ARB_RR_EN
        gD = !rrLastD;
        rrLastD = gD;
`else
        gD = 1;
`endif
      end else begin
        gD = bus.d_req;
      end
      act   = 1;
      start = cyc;
      eOwn  = gD;
      eAddr = gD ? bus.d_addr : bus.if_addr;
      eWr   = gD && bus.d_wr;
      eWd   = bus.d_wdata;
    end
    if (rst) begin
      act = 0; eCan = 0; eOwn = 0; rrLastD = 0;
      eIfR = '0; eDR = '0; postRst = 1;
    end
    cyc++;
  endtask

  task automatic driveIn(input bit fr, input logic [15:0] fa, input bit dr, input bit dw,
                         input logic [15:0] da, input logic [15:0] dd, input bit r);
    bus.if_req  = fr;
    bus.if_addr = fa;
    bus.d_req   = dr;
    bus.d_wr    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dd;
    rst         = r;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutputs();
      driveIn(0, '0, 0, 0, '0, '0, r);
      modelStep();
    end
  endtask

  // Hold requests until their done; dropAt drops fetch, rstAt pulses reset and abandons both.
  task automatic runTxn(input bit f, input logic [15:0] fa, input bit d, input bit dw,
                        input logic [15:0] da, input logic [15:0] dd,
                        input int dropAt, input int rstAt);
    bit fr, dr, fin;
    fr = f; dr = d; fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      checkOutputs();
      if (bus.if_done) fr = 0;
      if (bus.d_done)  dr = 0;
      if (i == dropAt) fr = 0;
      if (i == rstAt) begin fr = 0; dr = 0; end
      driveIn(fr, fa, dr, dw, da, dd, i == rstAt);
      modelStep();
      if (i > 0 && !fr && !dr && !act) fin = 1;
    end
    checkEq("txn_timeout", fin, 1);
  endtask

  initial begin
    bit fr, dr, dw, r;
    logic [15:0] fa, da, dd, v;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      simMem[i] = v;
      refMem[i] = v;
    end
    simMem[8'h10] = 16'h1234;
    refMem[8'h10] = 16'h1234;
    driveIn(0, '0, 0, 0, '0, '0, 1);
    repeat (2) @(posedge clk);

    // Reset held, then released with no requests.
    idle(2, 1);
    idle(3, 0);
    // Fetch of a preloaded word.
    runTxn(1, 16'h0010, 0, 0, '0, '0, -1, -1);
    idle(1, 0);
    // Store then load back the same address.
    runTxn(0, '0, 1, 1, 16'h0020, 16'hBEEF, -1, -1);
    runTxn(0, '0, 1, 0, 16'h0020, '0, -1, -1);
    checkEq("load_back", bus.d_rdata, 16'hBEEF);
    checkEq("fetch_kept", bus.if_rdata, 16'h1234);
    // Simultaneous requests, twice in a row.
    runTxn(1, 16'h0011, 1, 0, 16'h0012, '0, -1, -1);
    runTxn(1, 16'h0013, 1, 1, 16'h0014, 16'h5A5A, -1, -1);
    // Fetch dropped one cycle after its grant.
    runTxn(1, 16'h0015, 0, 0, '0, '0, 1, -1);
    idle(1, 0);
    // Store aborted by reset, then a normal load of the same address.
    runTxn(0, '0, 1, 1, 16'h0030, 16'hDEAD, -1, 1);
    runTxn(0, '0, 1, 0, 16'h0030, '0, -1, -1);
    idle(2, 0);

    fr = 0; dr = 0; dw = 0; fa = '0; da = '0; dd = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checkOutputs();
      if (fr && bus.if_done) fr = 0;
      else if (fr && $urandom_range(15) == 0) fr = 0;
      else if (!fr && $urandom_range(2) == 0) begin
        fr = 1;
        fa = {10'd0, 6'($urandom)};
      end
      if (dr && bus.d_done) dr = 0;
      else if (!dr && $urandom_range(2) == 0) begin
        dr = 1;
        dw = 1'($urandom);
        da = {10'd0, 6'($urandom)};
        dd = 16'($urandom);
      end
      r = ($urandom_range(299) == 0);
      driveIn(fr, fa, dr, dw, da, dd, r);
      modelStep();
    end
    idle(LAT + 3, 0);

    for (int i = 0; i < 256; i++) checkEq("mem_image", simMem[i], refMem[i]);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the CPU's single-port 16-bit word memory between the instruction-fetch path and the data (load/store) path. Each requester holds a request until a one-cycle done pulse. The arbiter owns the memory bus for a fixed multi-cycle access, then returns read data. It sits between the fetch/memory stages of mod_CPU and the memory model, and allows slow memory without changing the stage logic.

Parameters:
LATENCY, 2, cycles mem_en is held per access; legal range >= 1.
ADDR_W, 16, address width.
DATA_W, 16, data width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
if_req  in  1  fetch read request; held until if_done.
if_addr  in  ADDR_W  fetch address.
if_done  out  1  one-cycle pulse; if_rdata valid.
if_rdata  out  DATA_W  fetched word; holds until next fetch completion.
d_req  in  1  data request; held until d_done.
d_wr  in  1  1 = store, 0 = load.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  store data.
d_done  out  1  one-cycle pulse; d_rdata valid for loads.
d_rdata  out  DATA_W  load data; holds until next data completion.
mem_en  out  1  memory enable.
mem_wr  out  1  memory write; memory commits the write on the last mem_en cycle.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  combinational read data for mem_addr.
busy  out  1  high in ACCESS and RESP.
owner_d  out  1  1 = current or last grant was to the data port.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE. All outputs are 0: if_done, d_done, mem_en, mem_wr, mem_addr, mem_wdata, if_rdata, d_rdata, busy, owner_d. Internal cancel flag is 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - On any request: grant one port and latch its addr, wr and wdata into internal registers. Fetch requests latch wr=0. Set owner_d, load cnt = LATENCY-1, go to ACCESS.
- ACCESS:
  - mem_en=1. mem_wr, mem_addr and mem_wdata are driven from the latched registers and are stable for exactly LATENCY cycles.
  - Each cycle with cnt != 0: decrement cnt.
  - When cnt == 0: if the access is a read, capture mem_rdata into the owner's rdata register. Go to RESP.
- RESP:
  - mem_en=0. Pulse the owner's done for one cycle, unless the cancel flag is set. Clear the cancel flag and go to IDLE.
- Timing: request sampled in IDLE at cycle T. mem_en is high T+1..T+LATENCY. done is asserted at T+LATENCY+1. Next grant is possible at T+LATENCY+2.
- Requester must deassert req by the edge ending its done cycle. Otherwise the request is treated as a new one in IDLE.
- Arbitration (macro absent): fixed priority, data over fetch, when both are requesting in IDLE.
- Fetch cancel: if if_req goes low during ACCESS of a fetch, set cancel. The access completes, if_rdata is still updated, and if_done is suppressed.
- Data port: d_req must not drop mid-access. Behaviour if it does is undefined; stores always complete.
- Non-owner's done stays 0. The non-owner's rdata does not change.
- Reset asserted in any state: next edge returns to IDLE with all outputs 0. An in-flight access is aborted and no done is issued. A partially-held write is not committed, because mem_en drops before its last cycle.
- LATENCY=1: ACCESS lasts one cycle, and read data is captured in that cycle.

Optional Feature:
ARB_RR_EN
- Defined: round-robin. A last-grant flag (reset = fetch) gives the simultaneous-request tie to the port not granted last. The first tie after reset goes to data. A lone requester is always granted.
- Undefined: fixed data-over-fetch priority. The flag logic is not compiled.

Test Plan:
1. Hold rst=1 for 2 cycles, then release with no requests -> all outputs 0, state IDLE, busy=0.
2. Memory preloaded 0x1234 at 0x0010; if_req with if_addr=0x0010 at T -> mem_en=1, mem_wr=0, mem_addr=0x0010 at T+1..T+2; if_done=1 and if_rdata=0x1234 at T+3 only; busy=0 at T+4.
3. d_req, d_wr=1, addr 0x0020, wdata 0xBEEF -> mem_wr=1 for 2 cycles, d_done at T+3. Follow with a load of 0x0020 -> d_rdata=0xBEEF; if_rdata unchanged.
4. if_req and d_req both high at T -> data served, d_done at T+3; fetch granted at T+4, if_done at T+7. With ARB_RR_EN, a repeat tie at T+8 is served fetch-first.
5. if_req at T, dropped at T+1 -> mem_en still high at T+1..T+2, if_rdata updated, no if_done, IDLE at T+4.
6. Store granted at T; rst=1 at T+1 -> mem_en=0 from T+2, memory at the target address unchanged, no d_done. New request after rst release is served normally.
